// File: rtl/pcpu_pkg.sv
// pcpu_pkg: shared definitions for the pipelined CPU MEM stage.
//   - load/store opcode encodings (LB..SW)
//   - MEM sequencer state encoding
//   - byte-lane helpers: byte enables, store replication, load extension,
//     misalignment detection
package pcpu_pkg;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Byte enables for the access size, shifted into the addressed lane.
    function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] a);
        logic [3:0] be;
        case (op)
            LB, LBU, SB: be = 4'b0001 << a;
            LH, LHU, SH: be = 4'b0011 << a;
            LW, SW:      be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the size could occupy.
    function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] wd);
        logic [31:0] r;
        case (op)
            SB:      r = {4{wd[7:0]}};
            SH:      r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Little-endian lane select followed by sign/zero extension.
    function automatic logic [31:0] lane_ext(input logic [5:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rd >> {a, 3'b000};
        case (op)
            LB:      r = {{24{sh[7]}}, sh[7:0]};
            LBU:     r = {24'h000000, sh[7:0]};
            LH:      r = {{16{sh[15]}}, sh[15:0]};
            LHU:     r = {16'h0000, sh[15:0]};
            default: r = rd;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
        logic m;
        case (op)
            LH, LHU, SH: m = a[0];
            LW, SW:      m = |a;
            default:     m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational byte-lane alignment for the MEM stage.
//   op        in  6   load/store opcode
//   addr_lo   in  2   byte address bits [1:0]
//   wdata     in  32  raw store data
//   rdata     in  32  raw memory read word
//   be        out 4   byte enables
//   wdata_rep out 32  lane-replicated store data
//   rdata_ext out 32  lane-selected, extended load data
//   misalign  out 1   access not naturally aligned for its size
module mem_lane_align
    import pcpu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    always_comb begin
        be        = lane_be(op, addr_lo);
        wdata_rep = lane_wdata(op, wdata);
        rdata_ext = lane_ext(op, addr_lo, rdata);
        misalign  = misaligned(op, addr_lo);
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage sequencer. Drives a variable-latency data memory
// over req/ack, stalls upstream and bubbles MEM/WB while an access is open,
// aligns load/store lanes and flags misaligned and timed-out accesses.
//   clk, rst (async, active-high)
//   mem_read_i/mem_write_i/op_i/addr_i/wdata_i : EX/MEM inputs
//   dm_req_o/dm_we_o/dm_be_o/dm_addr_o/dm_wdata_o, dm_ack_i/dm_rdata_i : memory
//   stall_o, bubble_o     : pipeline control
//   rdata_o, rdata_valid_o: aligned load result for MEM/WB
//   misalign_o, timeout_o : one-cycle error pulses
module mem_stage_ctrl
    import pcpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [5:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic        stall_o,
    output logic        bubble_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t      state, next;
    logic [CW-1:0] cnt;
    logic        kill;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [5:0]  op_q;
    logic        we_q, rd_q;

    logic        mem_op, accept, timeout_hit;
    logic [5:0]  sel_op;
    logic [1:0]  sel_lo;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rdata_ext;
    logic        mis;

    // One aligner serves both phases: in IDLE it sees the incoming op to
    // build be/wdata for latching; afterwards it sees the latched op so the
    // returning read word is extended for the access actually in flight.
    assign sel_op = (state == IDLE) ? op_i : op_q;
    assign sel_lo = (state == IDLE) ? addr_i[1:0] : addr_q[1:0];

    mem_lane_align u_align (
        .op        (sel_op),
        .addr_lo   (sel_lo),
        .wdata     (wdata_i),
        .rdata     (dm_rdata_i),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .misalign  (mis)
    );

    assign mem_op      = mem_read_i | mem_write_i;
    assign accept      = (state == IDLE) && mem_op && !mis;
    assign timeout_hit = (state == ACCESS) && !dm_ack_i && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        next          = state;
        stall_o       = 1'b0;
        bubble_o      = 1'b0;
        dm_req_o      = 1'b0;
        misalign_o    = 1'b0;
        timeout_o     = 1'b0;
        rdata_valid_o = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    bubble_o = 1'b1;
                    if (mis) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        next    = ACCESS;
                    end
                end
            end
            ACCESS: begin
                dm_req_o = 1'b1;
                stall_o  = 1'b1;
                bubble_o = 1'b1;
                if (dm_ack_i) begin
                    next = DONE;
                end else if (timeout_hit) begin
                    timeout_o = 1'b1;
                    next      = DONE;
                end
            end
            DONE: begin
                bubble_o      = kill;
                rdata_valid_o = rd_q & ~kill;
                next          = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            kill    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                addr_q  <= addr_i;
                be_q    <= be;
                wdata_q <= wdata_rep;
                op_q    <= op_i;
                we_q    <= mem_write_i;
                rd_q    <= mem_read_i;
                cnt     <= '0;
                kill    <= 1'b0;
            end else if (state == ACCESS) begin
                cnt <= cnt + CW'(1);
                if (dm_ack_i) begin
                    rdata_q <= rdata_ext;
                end else if (timeout_hit) begin
                    kill <= 1'b1;
                end
            end
        end
    end

    assign dm_we_o    = we_q;
    assign dm_be_o    = be_q;
    assign dm_addr_o  = {addr_q[31:2], 2'b00};
    assign dm_wdata_o = wdata_q;
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_i, mem_write_i;
    logic [5:0]  op_i;
    logic [31:0] addr_i, wdata_i;
    logic        dm_req_o, dm_we_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_addr_o, dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
    logic        stall_o, bubble_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, misalign_o, timeout_o;

    int total = 0;
    int bad   = 0;

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .op_i          (op_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .dm_req_o      (dm_req_o),
        .dm_we_o       (dm_we_o),
        .dm_be_o       (dm_be_o),
        .dm_addr_o     (dm_addr_o),
        .dm_wdata_o    (dm_wdata_o),
        .dm_ack_i      (dm_ack_i),
        .dm_rdata_i    (dm_rdata_i),
        .stall_o       (stall_o),
        .bubble_o      (bubble_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misalign_o    (misalign_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [3:0]  be;
        logic [31:0] wrep;
        logic [31:0] rdata;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic [5:0] op, logic [31:0] addr,
                                logic [31:0] wd, logic [31:0] mr, logic [3:0] be,
                                logic [31:0] wrep, logic [31:0] rdata, logic mis);
        vec_t v;
        v.name = n; v.op = op; v.addr = addr; v.wdata = wd; v.mrdata = mr;
        v.be = be; v.wrep = wrep; v.rdata = rdata; v.mis = mis;
        v.wr = op[3];
        v.rd = ~op[3];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_i = 1'b0; mem_write_i = 1'b0; op_i = '0;
        addr_i = '0; wdata_i = '0; dm_ack_i = 1'b0; dm_rdata_i = '0;
    endtask

    // Apply one vector with ack in the first ACCESS cycle (or a misaligned op).
    task automatic run_vec(input vec_t v);
        mem_read_i = v.rd; mem_write_i = v.wr; op_i = v.op;
        addr_i = v.addr; wdata_i = v.wdata; dm_ack_i = 1'b0; dm_rdata_i = 32'h0;
        #1;
        if (v.mis) begin
            chk({v.name, " c0 misalign"}, {31'b0, misalign_o}, 32'd1);
            chk({v.name, " c0 bubble"},   {31'b0, bubble_o},   32'd1);
            chk({v.name, " c0 stall"},    {31'b0, stall_o},    32'd0);
            chk({v.name, " c0 req"},      {31'b0, dm_req_o},   32'd0);
            cyc();
            idle_inputs();
            #1;
            chk({v.name, " c1 misalign"}, {31'b0, misalign_o}, 32'd0);
            chk({v.name, " c1 req"},      {31'b0, dm_req_o},   32'd0);
            chk({v.name, " c1 stall"},    {31'b0, stall_o},    32'd0);
            return;
        end
        chk({v.name, " c0 stall"},  {31'b0, stall_o},  32'd1);
        chk({v.name, " c0 bubble"}, {31'b0, bubble_o}, 32'd1);
        chk({v.name, " c0 req"},    {31'b0, dm_req_o}, 32'd0);
        cyc();
        dm_ack_i = 1'b1; dm_rdata_i = v.mrdata;
        #1;
        chk({v.name, " c1 req"},   {31'b0, dm_req_o}, 32'd1);
        chk({v.name, " c1 stall"}, {31'b0, stall_o},  32'd1);
        chk({v.name, " c1 we"},    {31'b0, dm_we_o},  {31'b0, v.wr});
        chk({v.name, " c1 be"},    {28'b0, dm_be_o},  {28'b0, v.be});
        chk({v.name, " c1 addr"},  dm_addr_o,         {v.addr[31:2], 2'b00});
        if (v.wr) chk({v.name, " c1 wdata"}, dm_wdata_o, v.wrep);
        cyc();
        dm_ack_i = 1'b0; dm_rdata_i = 32'h0;
        #1;
        chk({v.name, " c2 stall"},  {31'b0, stall_o},       32'd0);
        chk({v.name, " c2 bubble"}, {31'b0, bubble_o},      32'd0);
        chk({v.name, " c2 req"},    {31'b0, dm_req_o},      32'd0);
        chk({v.name, " c2 valid"},  {31'b0, rdata_valid_o}, {31'b0, v.rd});
        if (v.rd) chk({v.name, " c2 rdata"}, rdata_o, v.rdata);
        cyc();
    endtask

    initial begin
        vec_t v;
        int   to_pulses;

        tbl.push_back(mk("lw100",  6'b100011, 32'h100, 32'h0,        32'h12345678, 4'b1111, 32'h0,        32'h12345678, 1'b0));
        tbl.push_back(mk("lb103",  6'b100000, 32'h103, 32'h0,        32'h80FFFF12, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0));
        tbl.push_back(mk("lbu103", 6'b100100, 32'h103, 32'h0,        32'h80FFFF12, 4'b1000, 32'h0,        32'h00000080, 1'b0));
        tbl.push_back(mk("sh102",  6'b101001, 32'h102, 32'h0000BEEF, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0));
        tbl.push_back(mk("lh102",  6'b100001, 32'h102, 32'h0,        32'h80017FFF, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0));
        tbl.push_back(mk("lhu102", 6'b100101, 32'h102, 32'h0,        32'h80017FFF, 4'b1100, 32'h0,        32'h00008001, 1'b0));
        tbl.push_back(mk("sb101",  6'b101000, 32'h101, 32'h000000A5, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0));
        tbl.push_back(mk("sw200",  6'b101011, 32'h200, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        1'b0));
        tbl.push_back(mk("lb101",  6'b100000, 32'h101, 32'h0,        32'h00008000, 4'b0010, 32'h0,        32'hFFFFFF80, 1'b0));
        tbl.push_back(mk("lb100",  6'b100000, 32'h100, 32'h0,        32'h0000007F, 4'b0001, 32'h0,        32'h0000007F, 1'b0));
        tbl.push_back(mk("lh101",  6'b100001, 32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
        tbl.push_back(mk("sw202",  6'b101011, 32'h202, 32'h11111111, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));
        tbl.push_back(mk("lw103",  6'b100011, 32'h103, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1));

        // Reset state
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("rst req",     {31'b0, dm_req_o},      32'd0);
        chk("rst stall",   {31'b0, stall_o},       32'd0);
        chk("rst valid",   {31'b0, rdata_valid_o}, 32'd0);
        chk("rst addr",    dm_addr_o,              32'd0);
        chk("rst be",      {28'b0, dm_be_o},       32'd0);
        chk("rst rdata",   rdata_o,                32'd0);
        chk("rst timeout", {31'b0, timeout_o},     32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Table vectors, back to back
        foreach (tbl[i]) run_vec(tbl[i]);

        // Timeout: LW with no ack, TIMEOUT=4
        to_pulses = 0;
        mem_read_i = 1'b1; op_i = 6'b100011; addr_i = 32'h300;
        #1;
        chk("to c0 stall", {31'b0, stall_o}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            #1;
            chk($sformatf("to c%0d req", k), {31'b0, dm_req_o}, 32'd1);
            chk($sformatf("to c%0d timeout", k), {31'b0, timeout_o}, (k == 4) ? 32'd1 : 32'd0);
            if (timeout_o) to_pulses++;
        end
        cyc();
        #1;
        chk("to done req",    {31'b0, dm_req_o},      32'd0);
        chk("to done bubble", {31'b0, bubble_o},      32'd1);
        chk("to done valid",  {31'b0, rdata_valid_o}, 32'd0);
        chk("to done stall",  {31'b0, stall_o},       32'd0);
        chk("to done tpulse", {31'b0, timeout_o},     32'd0);
        cyc();
        idle_inputs();
        dm_ack_i = 1'b1; dm_rdata_i = 32'hCAFEF00D;
        #1;
        chk("stray req",   {31'b0, dm_req_o}, 32'd0);
        chk("stray stall", {31'b0, stall_o},  32'd0);
        cyc();
        dm_ack_i = 1'b0;
        #1;
        chk("stray valid", {31'b0, rdata_valid_o}, 32'd0);
        chk("stray rdata", rdata_o,                32'h12345678 ^ 32'h12345678 ^ 32'h0000007F);
        chk("to pulses",   to_pulses,              32'd1);
        cyc();

        // Asynchronous reset in the 2nd ACCESS cycle
        mem_read_i = 1'b1; op_i = 6'b100011; addr_i = 32'h400;
        cyc();
        cyc();
        #1;
        chk("rstmid req before", {31'b0, dm_req_o}, 32'd1);
        rst = 1'b1; mem_read_i = 1'b0;
        #1;
        chk("rstmid req",   {31'b0, dm_req_o}, 32'd0);
        chk("rstmid stall", {31'b0, stall_o},  32'd0);
        chk("rstmid addr",  dm_addr_o,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        cyc();
        v = tbl[0];
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
